// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide unit.
// One radix-2 step per cycle: shift-add multiply on a double-width product,
// restoring divide on operand magnitudes. Signs are applied on completion.
// Division by zero and signed overflow finish immediately.

module muldiv_unit #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned OPCODE_LENGTH = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     Start,
   input  logic                     Flush,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   output logic                     Ready,
   output logic                     Busy,
   output logic                     Valid,
   output logic [DATA_WIDTH-1:0]    Result
);

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned CW = $clog2(DATA_WIDTH);

   localparam logic [OPCODE_LENGTH-1:0] OP_MUL    = OPCODE_LENGTH'(0);
   localparam logic [OPCODE_LENGTH-1:0] OP_MULH   = OPCODE_LENGTH'(1);
   localparam logic [OPCODE_LENGTH-1:0] OP_MULHSU = OPCODE_LENGTH'(2);
   localparam logic [OPCODE_LENGTH-1:0] OP_MULHU  = OPCODE_LENGTH'(3);
   localparam logic [OPCODE_LENGTH-1:0] OP_DIV    = OPCODE_LENGTH'(4);
   localparam logic [OPCODE_LENGTH-1:0] OP_DIVU   = OPCODE_LENGTH'(5);
   localparam logic [OPCODE_LENGTH-1:0] OP_REM    = OPCODE_LENGTH'(6);
   localparam logic [OPCODE_LENGTH-1:0] OP_REMU   = OPCODE_LENGTH'(7);

   localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
   localparam logic [CW-1:0] LAST_CNT = CW'(W-1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nx;

   // captured operation context
   logic [OPCODE_LENGTH-1:0] op_q;
   logic                     is_div_q;
   logic                     neg_res_q;
   logic                     neg_rem_q;
   logic [W-1:0]             opnd_q;
   logic [W-1:0]             hi_q;
   logic [W-1:0]             lo_q;
   logic [CW-1:0]            cnt_q;

   // input-side decode
   logic         in_quot;
   logic         in_rem;
   logic         in_div;
   logic         in_a_signed;
   logic         in_b_signed;
   logic         a_neg_in;
   logic         b_neg_in;
   logic [W-1:0] a_mag_in;
   logic [W-1:0] b_mag_in;
   logic         in_div0;
   logic         in_ovf;
   logic         in_exc;
   logic [W-1:0] exc_result;

   // iteration datapath
   logic [W:0]   sum;
   logic [W:0]   rem_shift;
   logic [W:0]   diff;
   logic [W-1:0] hi_nx;
   logic [W-1:0] lo_nx;

   // completion datapath
   logic [2*W-1:0] prod;
   logic [2*W-1:0] prod_s;
   logic [W-1:0]   quo_s;
   logic [W-1:0]   rem_s;
   logic [W-1:0]   final_result;

   // control strobes
   logic accept;
   logic last;
   logic load_exc;
   logic load_final;

   // decode operation class, signedness and magnitudes of the incoming request
   always_comb begin
      in_quot     = (Operation == OP_DIV) || (Operation == OP_DIVU);
      in_rem      = (Operation == OP_REM) || (Operation == OP_REMU);
      in_div      = in_quot || in_rem;
      in_a_signed = (Operation == OP_MUL) || (Operation == OP_MULH) ||
                    (Operation == OP_MULHSU) || (Operation == OP_DIV) ||
                    (Operation == OP_REM);
      in_b_signed = (Operation == OP_MUL) || (Operation == OP_MULH) ||
                    (Operation == OP_DIV) || (Operation == OP_REM);
      a_neg_in    = in_a_signed && SrcA[W-1];
      b_neg_in    = in_b_signed && SrcB[W-1];
      a_mag_in    = a_neg_in ? (-SrcA) : SrcA;
      b_mag_in    = b_neg_in ? (-SrcB) : SrcB;
      in_div0     = in_div && (SrcB == '0);
      in_ovf      = ((Operation == OP_DIV) || (Operation == OP_REM)) &&
                    (SrcA == MIN_VAL) && (SrcB == '1);
      in_exc      = in_div0 || in_ovf;
   end

   // immediate results for divide-by-zero and signed overflow
   always_comb begin
      exc_result = '0;
      if (in_div0) begin
         exc_result = in_quot ? '1 : SrcA;
      end else if (in_ovf) begin
         exc_result = (Operation == OP_DIV) ? MIN_VAL : '0;
      end
   end

   // control strobes shared by the FSM and datapath
   always_comb begin
      accept     = (state == S_IDLE) && Start && !Flush;
      last       = (cnt_q == LAST_CNT);
      load_exc   = accept && in_exc;
      load_final = (state == S_RUN) && !Flush && last;
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // next-state logic; Flush overrides progress in every state
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nx = in_exc ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (Flush) begin
               state_nx = S_IDLE;
            end else if (last) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // status outputs decoded purely from the state register
   always_comb begin
      Ready = 1'b0;
      Busy  = 1'b0;
      Valid = 1'b0;
      case (state)
         S_IDLE: begin
            Ready = 1'b1;
         end
         S_RUN: begin
            Busy = 1'b1;
         end
         S_DONE: begin
            Busy  = 1'b1;
            Valid = 1'b1;
         end
         default: begin
            Ready = 1'b0;
         end
      endcase
   end

   // step counter: zero on entry to RUN, advances while RUN continues
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if ((state == S_RUN) && (state_nx == S_RUN)) begin
         cnt_q <= cnt_q + CW'(1);
      end else begin
         cnt_q <= '0;
      end
   end

   // one radix-2 step: shift-add multiply or restoring divide
   always_comb begin
      sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      rem_shift = {hi_q, lo_q[W-1]};
      diff      = rem_shift - {1'b0, opnd_q};
      if (is_div_q) begin
         hi_nx = diff[W] ? rem_shift[W-1:0] : diff[W-1:0];
         lo_nx = {lo_q[W-2:0], ~diff[W]};
      end else begin
         hi_nx = sum[W:1];
         lo_nx = {sum[0], lo_q[W-1:1]};
      end
   end

   // apply signs to the final step's values and select the requested half
   always_comb begin
      prod         = {hi_nx, lo_nx};
      prod_s       = neg_res_q ? (-prod) : prod;
      quo_s        = neg_res_q ? (-lo_nx) : lo_nx;
      rem_s        = neg_rem_q ? (-hi_nx) : hi_nx;
      final_result = '0;
      case (op_q)
         OP_MUL:                       final_result = prod_s[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod_s[2*W-1:W];
         OP_DIV, OP_DIVU:              final_result = quo_s;
         OP_REM, OP_REMU:              final_result = rem_s;
         default:                      final_result = '0;
      endcase
   end

   // operand capture on acceptance, iteration while running
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q      <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         opnd_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else if (accept) begin
         op_q      <= Operation;
         is_div_q  <= in_div;
         neg_res_q <= a_neg_in ^ b_neg_in;
         neg_rem_q <= a_neg_in;
         opnd_q    <= in_div ? b_mag_in : a_mag_in;
         hi_q      <= '0;
         lo_q      <= in_div ? a_mag_in : b_mag_in;
      end else if (state == S_RUN) begin
         hi_q <= hi_nx;
         lo_q <= lo_nx;
      end
   end

   // result register: written only on the edge entering DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         Result <= '0;
      end else if (load_exc) begin
         Result <= exc_result;
      end else if (load_final) begin
         Result <= final_result;
      end
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand/result width in bits (even, >= 8).
REQ-002 SHALL have parameter OPCODE_LENGTH, default 3: width of Operation (RV32M funct3 encoding).
REQ-003 SHALL use one clock and a synchronous, active-high reset, as listed next.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 Start  input  1  request; sampled only when Ready=1.
REQ-007 Flush  input  1  abort the in-flight operation (pipeline flush).
REQ-008 Operation  input  OPCODE_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 SrcA  input  DATA_WIDTH  multiplicand / dividend.
REQ-010 SrcB  input  DATA_WIDTH  multiplier / divisor.
REQ-011 Ready  output  1  high only in IDLE.
REQ-012 Busy  output  1  high in RUN or DONE; drives the pipeline stall.
REQ-013 Valid  output  1  one-cycle pulse: Result is valid.
REQ-014 Result  output  DATA_WIDTH  registered result; holds its value until the next DONE.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-016 IDLE: Start=1 and Flush=0 at an edge captures SrcA, SrcB and Operation into internal registers; next state is RUN with a cycle counter of 0.
REQ-017 Exception: DIV/DIVU/REM/REMU with SrcB=0, or DIV/REM with SrcA=most-negative and SrcB=all-ones, SHALL go IDLE->DONE directly (Valid on the next cycle).
REQ-018 RUN SHALL perform one radix-2 step per cycle for exactly DATA_WIDTH cycles: shift-add multiply on a 2*DATA_WIDTH product, or restoring divide on magnitudes.
REQ-019 After the counter reaches DATA_WIDTH-1, RUN SHALL go to DONE.
REQ-020 DONE SHALL last one cycle with Valid=1, then return to IDLE; Result SHALL be loaded on the edge entering DONE.
REQ-021 Normal latency: Valid high DATA_WIDTH+1 cycles after the accepting edge (33 cycles at DATA_WIDTH=32).
REQ-022 Start SHALL be ignored outside IDLE; captured operands SHALL be unaffected by input changes during RUN.
REQ-023 Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats SrcA as signed and SrcB as unsigned; MULHU/DIVU/REMU treat both as unsigned.
REQ-024 Signed ops SHALL use magnitudes with the sign fixed at completion; the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.
REQ-025 MUL SHALL return the low DATA_WIDTH bits of the product; MULH/MULHSU/MULHU SHALL return the high DATA_WIDTH bits.
REQ-026 Divide by zero: quotient SHALL be all-ones; remainder SHALL be SrcA.
REQ-027 Signed overflow: DIV SHALL return most-negative; REM SHALL return 0.
REQ-028 Flush=1 in RUN or DONE SHALL force IDLE next cycle with Valid=0 and Result unchanged; in IDLE it SHALL block acceptance.
REQ-029 Flush and Start in the same IDLE cycle: Flush SHALL win and nothing is accepted.
REQ-030 Ready, Busy and Valid SHALL be decoded from the state register only (no combinational path from inputs).

Reset
REQ-031 reset=1 at an edge SHALL force IDLE, Result=0, Valid=0, Busy=0, Ready=1 and counter=0, and SHALL override Start and Flush.
REQ-032 reset asserted mid-RUN SHALL discard the operation with no Valid pulse afterwards.

Verification (DATA_WIDTH=32)
REQ-033 MUL 7 x 0xFFFFFFFD, Start at cycle 0 -> Busy cycles 1..33, Valid cycle 33 only, Result=0xFFFFFFEB.
REQ-034 MULH/MULHU/MULHSU 0x80000000 x 0x80000000 -> 0x40000000 / 0x40000000 / 0xC0000000.
REQ-035 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-036 DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0; Valid one cycle after Start in all four cases.
REQ-037 Flush at RUN cycle 10 -> IDLE next cycle, no Valid, Result keeps its prior value; an immediate new Start completes correctly.
REQ-038 reset at RUN cycle 5, or Start while Busy -> reset returns all outputs to reset values; a Start while Busy is ignored and the first result is unaffected.
